// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose:
//   Issue/sequencing controller for a small 16-bit accumulator-style core.
//   It accepts one instruction at a time and drives the external register
//   file, ALU and data cache. It then writes the result back and returns to
//   IDLE for the next instruction. The flow is IDLE -> EXEC -> (MEM) -> (WB)
//   -> IDLE. HLT parks the block in HALT until reset.
//
// Instruction word:
//   opcode[15:12] rs[11:10] rt[9:8] rd[7:6] func[5:0] imm[7:0]
//   Supported opcodes and functions:
//     ADI=4, ORI=5, LHI=6, LWD=7, SWD=8
//     opcode 15 with the following funcs:
//       ADD..SHR = 0..7
//       WWD      = 28
//       HLT      = 29
//   Any other combination is flagged as illegal.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   inst_valid/inst_ready     instruction handshake (ready only in IDLE)
//   inst[15:0]                instruction word
//   rf_raddr1/2, rf_rdata1/2  asynchronous register-file read port (rs / rt)
//   alu_a/b, alu_opcode,      operands and operation for the external
//   alu_func, alu_c           combinational ALU, and its result
//   mem_req/we/addr/wdata,    data-cache request; held stable until mem_ack
//   mem_rdata, mem_ack
//   rf_we/waddr/wdata         register write-back port (one-cycle strobe)
//   output_port               value captured by WWD
//   halted                    set once HLT executes
//   illegal                   one-cycle pulse in EXEC for unsupported instr.
//   num_inst (optional)       retired-instruction counter
//
// Configuration:
//   RETIRE_CNT_EN  when defined, adds the 16-bit num_inst output. It counts
//                  every instruction that retires (illegal ones included)
//                  and wraps at 0xFFFF.
// -----------------------------------------------------------------------------
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [15:0] inst,
    output logic [1:0]  rf_raddr1,
    output logic [1:0]  rf_raddr2,
    input  logic [15:0] rf_rdata1,
    input  logic [15:0] rf_rdata2,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_opcode,
    output logic [5:0]  alu_func,
    input  logic [15:0] alu_c,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [1:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [15:0] output_port,
    output logic        halted,
    output logic        illegal
`ifdef RETIRE_CNT_EN
    ,
    output logic [15:0] num_inst
`endif
);

    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FUNC_SHR = 6'd7;
    localparam logic [5:0] FUNC_WWD = 6'd28;
    localparam logic [5:0] FUNC_HLT = 6'd29;

    typedef enum logic [2:0] {IDLE, EXEC, MEM, WB, HALT} state_t;

    // Instruction class, decided once at acceptance, so EXEC only has to
    // look at a few bits to pick its next state.
    typedef enum logic [2:0] {
        CLS_ALU, CLS_LOAD, CLS_STORE, CLS_WWD, CLS_HALT, CLS_ILL
    } cls_t;

    state_t      state;
    cls_t        ir_cls;
    logic [15:0] ir;
    logic [15:0] result;
    logic [15:0] store_data;
    logic [7:0]  imm;

    // Sort a raw instruction word into one of the classes the sequencer
    // handles. R-type funcs 0..7 are the plain ALU operations.
    function automatic cls_t classify(input logic [15:0] w);
        cls_t c;
        case (w[15:12])
            OP_ADI, OP_ORI, OP_LHI: c = CLS_ALU;
            OP_LWD:                 c = CLS_LOAD;
            OP_SWD:                 c = CLS_STORE;
            OP_RTYPE: begin
                if (w[5:0] <= FUNC_SHR)      c = CLS_ALU;
                else if (w[5:0] == FUNC_WWD) c = CLS_WWD;
                else if (w[5:0] == FUNC_HLT) c = CLS_HALT;
                else                         c = CLS_ILL;
            end
            default:                c = CLS_ILL;
        endcase
        return c;
    endfunction

    assign imm = ir[7:0];

    // The handshake is only offered from IDLE. It is also masked while reset
    // is asserted, so ready stays low for the whole reset window.
    assign inst_ready = (state == IDLE) && reset_n;

    // The register file and ALU are combinational, so their addresses and
    // operands come straight from the latched instruction. They are
    // meaningful during EXEC, which is when the result is captured.
    assign rf_raddr1  = ir[11:10];
    assign rf_raddr2  = ir[9:8];
    assign alu_opcode = ir[15:12];
    assign alu_func   = ir[5:0];
    assign alu_a      = rf_rdata1;

    // The second ALU operand depends on the instruction format. R-type uses
    // rt. Address and add-immediate forms sign-extend the immediate. The
    // logical/upper-immediate forms zero-extend it.
    always_comb begin
        alu_b = rf_rdata2;
        case (ir[15:12])
            OP_ADI, OP_LWD, OP_SWD: alu_b = {{8{imm[7]}}, imm};
            OP_ORI, OP_LHI:         alu_b = {8'h00, imm};
            default:                alu_b = rf_rdata2;
        endcase
    end

    // The memory address and store data are held in registers captured at
    // the end of EXEC. This keeps them stable for however long the cache
    // takes to respond. R-type instructions write rd; immediate forms and
    // loads write rt.
    assign mem_addr  = result;
    assign mem_wdata = store_data;
    assign rf_waddr  = (ir[15:12] == OP_RTYPE) ? ir[7:6] : ir[9:8];
    assign rf_wdata  = result;

    // Main sequencer. All control strobes are registers set on the edge
    // that enters the state where they belong:
    //   illegal  high only in EXEC
    //   mem_req  high only in MEM
    //   rf_we    high only in WB
    // rf_we and illegal default back to 0 every cycle, which makes them
    // one-cycle pulses. mem_req/mem_we are held explicitly until the ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            ir_cls      <= CLS_ILL;
            ir          <= 16'h0000;
            result      <= 16'h0000;
            store_data  <= 16'h0000;
            output_port <= 16'h0000;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            rf_we       <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
        end else begin
            illegal <= 1'b0;
            rf_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        ir      <= inst;
                        ir_cls  <= classify(inst);
                        illegal <= (classify(inst) == CLS_ILL);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    result     <= alu_c;
                    store_data <= rf_rdata2;
                    case (ir_cls)
                        CLS_ALU: begin
                            rf_we <= 1'b1;
                            state <= WB;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            mem_req <= 1'b1;
                            mem_we  <= (ir_cls == CLS_STORE);
                            state   <= MEM;
                        end
                        CLS_WWD: begin
                            output_port <= rf_rdata1;
                            state       <= IDLE;
                        end
                        CLS_HALT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        default: state <= IDLE;
                    endcase
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (ir_cls == CLS_LOAD) begin
                            result <= mem_rdata;
                            rf_we  <= 1'b1;
                            state  <= WB;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WB:      state <= IDLE;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RETIRE_CNT_EN
    logic retire;

    // An instruction retires on the cycle it leaves the pipeline for good:
    //   - WWD, HLT and illegal instructions leave directly from EXEC
    //   - stores leave from MEM on the ack
    //   - everything that writes back leaves from WB
    assign retire = ((state == EXEC) &&
                     ((ir_cls == CLS_WWD) || (ir_cls == CLS_HALT) || (ir_cls == CLS_ILL))) ||
                    ((state == MEM) && mem_ack && (ir_cls == CLS_STORE)) ||
                    (state == WB);

    // Free-running retire counter. It wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_inst <= 16'h0000;
        end else if (retire) begin
            num_inst <= num_inst + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl. The bench provides the register
// file, ALU and a variable-latency data cache around the controller. It
// predicts the architectural effect of every instruction from an
// instruction-level reference model. Stimulus consists of directed cases
// followed by randomized instructions.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_WWD   = 3;
    localparam int K_HALT  = 4;
    localparam int K_ILL   = 5;

    typedef struct {
        int          kind;
        logic [1:0]  waddr;
        logic [15:0] wdata;
        logic [15:0] addr;
        logic [15:0] sdata;
        logic [15:0] outp;
        bit          b_valid;
        logic [15:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [1:0]  rf_raddr1, rf_raddr2;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [3:0]  alu_opcode;
    logic [5:0]  alu_func;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack = 1'b0;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] output_port;
    logic        halted, illegal;
`ifdef RETIRE_CNT_EN
    logic [15:0] num_inst;
`endif

    logic [15:0] regs [4];
    logic [15:0] mem  [256];
    logic        pre_reg_en = 1'b0;
    logic [1:0]  pre_reg_addr = 2'd0;
    logic [15:0] pre_reg_data = 16'h0000;
    logic        pre_mem_en = 1'b0;
    logic [7:0]  pre_mem_addr = 8'd0;
    logic [15:0] pre_mem_data = 16'h0000;

    logic [15:0] ref_regs [4];
    logic [15:0] ref_mem  [256];
    logic [15:0] ref_outp;
    int          ref_retired;

    int ack_wait  = 0;
    int ack_cnt   = 0;
    bit stray_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_func    (alu_func),
        .alu_c       (alu_c),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .output_port (output_port),
        .halted      (halted),
        .illegal     (illegal)
`ifdef RETIRE_CNT_EN
        ,
        .num_inst    (num_inst)
`endif
    );

    // External ALU as the core would see it.
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [5:0] fn,
                                           input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            4'd15: case (fn)
                6'd0: r = a + b;
                6'd1: r = a - b;
                6'd2: r = a & b;
                6'd3: r = a | b;
                6'd4: r = ~a;
                6'd5: r = ~a + 16'd1;
                6'd6: r = a << 1;
                6'd7: r = 16'($signed(a) >>> 1);
                default: r = a;
            endcase
            4'd4, 4'd7, 4'd8: r = a + b;
            4'd5:             r = a | b;
            4'd6:             r = b << 8;
            default:          r = 16'h0000;
        endcase
        return r;
    endfunction

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];
    assign alu_c     = alu_fn(alu_opcode, alu_func, alu_a, alu_b);
    assign mem_rdata = mem[mem_addr[7:0]];

    // Register file and cache storage. They are written by the DUT, or by
    // the bench when it preloads them.
    always @(posedge clk) begin
        if (rf_we)                      regs[rf_waddr]     <= rf_wdata;
        if (pre_reg_en)                 regs[pre_reg_addr] <= pre_reg_data;
        if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (pre_mem_en)                 mem[pre_mem_addr]  <= pre_mem_data;
    end

    // Cache responder. It acks after ack_wait idle request cycles.
    // stray_ack forces an ack regardless of any request.
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack = (ack_cnt >= ack_wait) || stray_ack;
            ack_cnt = ack_cnt + 1;
        end else begin
            mem_ack = stray_ack;
            ack_cnt = 0;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input logic [1:0] idx, input logic [15:0] val);
        @(negedge clk);
        pre_reg_en = 1'b1; pre_reg_addr = idx; pre_reg_data = val;
        @(negedge clk);
        pre_reg_en = 1'b0;
        ref_regs[idx] = val;
    endtask

    task automatic set_mem(input logic [7:0] idx, input logic [15:0] val);
        @(negedge clk);
        pre_mem_en = 1'b1; pre_mem_addr = idx; pre_mem_data = val;
        @(negedge clk);
        pre_mem_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    function automatic logic [15:0] rtype(input int fn, input int rs, input int rt, input int rd);
        return {4'hF, 2'(rs), 2'(rt), 2'(rd), 6'(fn)};
    endfunction

    function automatic logic [15:0] itype(input int op, input int rs, input int rt, input int imm);
        return {4'(op), 2'(rs), 2'(rt), 8'(imm)};
    endfunction

    // Instruction-level reference: what the instruction does to the
    // architectural state.
    function automatic exp_t predict(input logic [15:0] w);
        exp_t        e;
        logic [1:0]  rs, rt, rd;
        logic [7:0]  imm;
        logic [15:0] a, bt, sx, zx;
        rs  = w[11:10]; rt = w[9:8]; rd = w[7:6]; imm = w[7:0];
        a   = ref_regs[rs];
        bt  = ref_regs[rt];
        sx  = {{8{imm[7]}}, imm};
        zx  = {8'h00, imm};
        e   = '{default: 0};
        e.kind = K_ILL;
        e.outp = ref_outp;
        case (w[15:12])
            4'd4: begin e.kind = K_ALU; e.waddr = rt; e.wdata = a + sx; e.b_valid = 1; e.b = sx; end
            4'd5: begin e.kind = K_ALU; e.waddr = rt; e.wdata = a | zx; e.b_valid = 1; e.b = zx; end
            4'd6: begin e.kind = K_ALU; e.waddr = rt; e.wdata = {imm, 8'h00}; e.b_valid = 1; e.b = zx; end
            4'd7: begin
                e.kind = K_LOAD; e.addr = a + sx; e.waddr = rt;
                e.wdata = ref_mem[e.addr[7:0]]; e.b_valid = 1; e.b = sx;
            end
            4'd8: begin e.kind = K_STORE; e.addr = a + sx; e.sdata = bt; e.b_valid = 1; e.b = sx; end
            4'd15: begin
                e.b_valid = 1; e.b = bt; e.waddr = rd; e.kind = K_ALU;
                case (w[5:0])
                    6'd0:  e.wdata = a + bt;
                    6'd1:  e.wdata = a - bt;
                    6'd2:  e.wdata = a & bt;
                    6'd3:  e.wdata = a | bt;
                    6'd4:  e.wdata = ~a;
                    6'd5:  e.wdata = 16'd0 - a;
                    6'd6:  e.wdata = {a[14:0], 1'b0};
                    6'd7:  e.wdata = {a[15], a[15:1]};
                    6'd28: begin e.kind = K_WWD; e.outp = a; end
                    6'd29: e.kind = K_HALT;
                    default: e.kind = K_ILL;
                endcase
            end
            default: e.kind = K_ILL;
        endcase
        return e;
    endfunction

    // Issue one instruction, watch it until the controller is ready again
    // (or halts), then compare everything it did against the reference.
    task automatic applyStimulus(input logic [15:0] w);
        exp_t        e;
        int          cycles, we_cnt, req_cnt, ill_cnt, mwe_cnt, exp_lat;
        bit          unstable;
        logic [1:0]  waddr_seen;
        logic [15:0] wdata_seen, addr_seen, sdata_seen, b_seen;
        e = predict(w);
        we_cnt = 0; req_cnt = 0; ill_cnt = 0; mwe_cnt = 0; unstable = 0;
        waddr_seen = 0; wdata_seen = 0; addr_seen = 0; sdata_seen = 0; b_seen = 0;
        @(negedge clk);
        inst = w; inst_valid = 1'b1;
        checkOutput("ready_before_issue", inst_ready, 1);
        @(negedge clk);
        inst_valid = 1'b0; inst = 16'($urandom);
        cycles = 1;
        while (!inst_ready && !halted && cycles < 40) begin
            if (cycles == 1) b_seen = alu_b;
            if (rf_we) begin we_cnt++; waddr_seen = rf_waddr; wdata_seen = rf_wdata; end
            if (illegal) ill_cnt++;
            if (mem_req) begin
                if (req_cnt == 0) addr_seen = mem_addr;
                else if (mem_addr !== addr_seen) unstable = 1;
                if (mem_we) begin mwe_cnt++; sdata_seen = mem_wdata; end
                req_cnt++;
            end
            @(negedge clk);
            cycles++;
        end
        case (e.kind)
            K_ALU:   exp_lat = 3;
            K_LOAD:  exp_lat = 4 + ack_wait;
            K_STORE: exp_lat = 3 + ack_wait;
            default: exp_lat = 2;
        endcase
        checkOutput("latency", cycles, exp_lat);
        checkOutput("rf_we_cycles", we_cnt, (e.kind == K_ALU || e.kind == K_LOAD) ? 1 : 0);
        checkOutput("illegal_cycles", ill_cnt, (e.kind == K_ILL) ? 1 : 0);
        checkOutput("mem_req_cycles", req_cnt,
                    (e.kind == K_LOAD || e.kind == K_STORE) ? ack_wait + 1 : 0);
        checkOutput("halted", halted, (e.kind == K_HALT) ? 1 : 0);
        if (e.b_valid) checkOutput("alu_b", b_seen, e.b);
        if (e.kind == K_ALU || e.kind == K_LOAD) begin
            checkOutput("rf_waddr", waddr_seen, e.waddr);
            checkOutput("rf_wdata", wdata_seen, e.wdata);
            ref_regs[e.waddr] = e.wdata;
        end
        if (e.kind == K_LOAD || e.kind == K_STORE) begin
            checkOutput("mem_addr", addr_seen, e.addr);
            checkOutput("mem_addr_stable", unstable, 0);
            checkOutput("mem_we_cycles", mwe_cnt, (e.kind == K_STORE) ? req_cnt : 0);
        end
        if (e.kind == K_STORE) begin
            checkOutput("mem_wdata", sdata_seen, e.sdata);
            ref_mem[e.addr[7:0]] = e.sdata;
        end
        ref_outp = e.outp;
        checkOutput("output_port", output_port, ref_outp);
        ref_retired++;
    endtask

    initial begin
        logic [15:0] w;
        int          bad, pick, f;
        logic [3:0]  illops [10];
        illops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
        reset_n = 1'b0; inst_valid = 1'b0; inst = 16'h0000;
        ref_outp = 16'h0000; ref_retired = 0;

        // Preload storage while the controller sits in reset.
        for (int i = 0; i < 256; i++) set_mem(i[7:0], 16'($urandom));
        for (int i = 0; i < 4; i++) set_reg(i[1:0], 16'($urandom));
        @(negedge clk);
        checkOutput("reset_inst_ready", inst_ready, 0);
        checkOutput("reset_halted", halted, 0);
        checkOutput("reset_rf_we", rf_we, 0);
        checkOutput("reset_mem_req", mem_req, 0);
        checkOutput("reset_illegal", illegal, 0);
        checkOutput("reset_output_port", output_port, 16'h0000);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", inst_ready, 1);

        // Directed cases.
        set_reg(1, 16'h0003); set_reg(2, 16'h0004);
        applyStimulus(rtype(0, 1, 2, 3));
        set_reg(0, 16'h0010);
        applyStimulus(itype(4, 0, 1, 8'hFF));
        set_reg(2, 16'h1200);
        applyStimulus(itype(5, 2, 3, 8'hFF));
        applyStimulus(itype(6, 1, 0, 8'hA5));
        set_reg(0, 16'h0100); set_mem(8'h05, 16'hBEEF);
        ack_wait = 2;
        applyStimulus(itype(7, 0, 2, 8'h05));
        ack_wait = 0;
        applyStimulus(itype(7, 0, 1, 8'h05));
        ack_wait = 1;
        applyStimulus(itype(8, 0, 3, 8'h10));
        set_reg(1, 16'h1234);
        applyStimulus(rtype(28, 1, 0, 0));
        applyStimulus(itype(0, 1, 2, 8'h04));
        applyStimulus(rtype(25, 1, 2, 0));

        // Randomized instruction mix.
        for (int n = 0; n < 150; n++) begin
            ack_wait = $urandom_range(0, 3);
            pick = $urandom_range(0, 9);
            w = 16'($urandom);
            case (pick)
                0: w[15:12] = 4'd4;
                1: w[15:12] = 4'd5;
                2: w[15:12] = 4'd6;
                3: w[15:12] = 4'd7;
                4: w[15:12] = 4'd8;
                5, 6: begin w[15:12] = 4'd15; w[5:0] = 6'($urandom_range(0, 7)); end
                7: begin w[15:12] = 4'd15; w[5:0] = 6'd28; end
                8: w[15:12] = illops[$urandom_range(0, 9)];
                default: begin
                    f = $urandom_range(8, 63);
                    if (f == 28 || f == 29) f = 26;
                    w[15:12] = 4'd15; w[5:0] = 6'(f);
                end
            endcase
            applyStimulus(w);
        end
`ifdef RETIRE_CNT_EN
        checkOutput("num_inst", num_inst, 16'(ref_retired));
`endif

        // Reset while a load waits on the cache, then a stray ack in IDLE.
        ack_wait = 1000;
        @(negedge clk);
        inst = itype(7, 0, 1, 8'h20); inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mem_req_waiting", mem_req, 1);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("mem_req_after_reset", mem_req, 0);
        checkOutput("ready_in_reset", inst_ready, 0);
        reset_n = 1'b1;
        ref_outp = 16'h0000; ref_retired = 0;
        #1;
        checkOutput("ready_after_mem_reset", inst_ready, 1);
        ack_wait = 0; stray_ack = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rf_we || mem_req || illegal || !inst_ready) bad++;
        end
        stray_ack = 1'b0;
        checkOutput("stray_ack_ignored", bad, 0);
        applyStimulus(rtype(0, 1, 2, 3));
        applyStimulus(itype(8, 2, 0, 8'h7F));

        // HLT parks the controller until reset.
        applyStimulus(rtype(29, 0, 0, 0));
`ifdef RETIRE_CNT_EN
        checkOutput("num_inst_after_halt", num_inst, 16'(ref_retired));
`endif
        inst = rtype(0, 1, 2, 3); inst_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (inst_ready || !halted || rf_we || mem_req) bad++;
        end
        checkOutput("halt_hold", bad, 0);
        inst_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("halt_cleared", halted, 0);
        checkOutput("ready_after_halt_reset", inst_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
